// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA raster timing generator:
//   phase_t        - per-axis raster phase (active, front porch, sync, back porch)
//   VGA_*          - default 640x480@60 timing segment lengths
//   VGA_H_TOTAL    - pixels per line including blanking
//   VGA_V_TOTAL    - lines per frame including blanking
package vga_pkg;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage

// File: rtl/vga_if.sv
// vga_if
// Bundle between the raster generator and its consumers (SRAM address
// counter, read/write sequencer, display pins).
//   i_en          - run enable, driven by the consumer side
//   o_h_cnt       - horizontal position
//   o_v_cnt       - vertical position
//   o_hsync       - horizontal sync, active low
//   o_vsync       - vertical sync, active low
//   o_active      - visible-region flag
//   o_addr_inc    - one pulse per visible pixel
//   o_pix_tick    - pixel-rate strobe
//   o_frame_start - pulse at pixel (0,0)
// Modports: master = generator, slave = consumer.
interface vga_if #(
    parameter int CNT_WIDTH = 10
);
    logic                 i_en;
    logic [CNT_WIDTH-1:0] o_h_cnt;
    logic [CNT_WIDTH-1:0] o_v_cnt;
    logic                 o_hsync;
    logic                 o_vsync;
    logic                 o_active;
    logic                 o_addr_inc;
    logic                 o_pix_tick;
    logic                 o_frame_start;

    modport master (
        input  i_en,
        output o_h_cnt, o_v_cnt, o_hsync, o_vsync, o_active,
        output o_addr_inc, o_pix_tick, o_frame_start
    );

    modport slave (
        output i_en,
        input  o_h_cnt, o_v_cnt, o_hsync, o_vsync, o_active,
        input  o_addr_inc, o_pix_tick, o_frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis: position counter plus phase FSM.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear to position 0 / ACT
//   step       - advance one position
//   cnt        - current position, 0..TOTAL-1
//   phase      - phase of the current position
//   wrap       - high while a step moves the counter from TOTAL-1 to 0
//
// state   | meaning
// ST_ACT  | position in the visible segment
// ST_FP   | position in the front porch
// ST_SYNC | position in the sync pulse
// ST_BP   | position in the back porch
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int WIDTH  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    output logic [WIDTH-1:0] cnt,
    output phase_t           phase,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    // Last position of each segment: a step from here lands on the next boundary.
    localparam logic [WIDTH-1:0] END_ACT  = WIDTH'(ACTIVE - 1);
    localparam logic [WIDTH-1:0] END_FP   = WIDTH'(ACTIVE + FP - 1);
    localparam logic [WIDTH-1:0] END_SYNC = WIDTH'(ACTIVE + FP + SYNC - 1);
    localparam logic [WIDTH-1:0] LAST     = WIDTH'(TOTAL - 1);

    localparam logic [1:0] ST_ACT  = 2'd0;
    localparam logic [1:0] ST_FP   = 2'd1;
    localparam logic [1:0] ST_SYNC = 2'd2;
    localparam logic [1:0] ST_BP   = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;

    assign wrap  = step && (cnt == LAST);
    assign phase = phase_t'(state);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACT:  if (cnt == END_ACT)  state_nxt = ST_FP;
            ST_FP:   if (cnt == END_FP)   state_nxt = ST_SYNC;
            ST_SYNC: if (cnt == END_SYNC) state_nxt = ST_BP;
            default: if (cnt == LAST)     state_nxt = ST_ACT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            state <= ST_ACT;
        end else if (clr) begin
            cnt   <= '0;
            state <= ST_ACT;
        end else if (step) begin
            cnt   <= wrap ? '0 : cnt + WIDTH'(1);
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// VGA raster timing generator (640x480@60 by default). Drives sync,
// visible-region flag, one address-increment pulse per visible pixel and a
// frame-start pulse at pixel (0,0).
//   i_clk - system clock
//   i_rst - asynchronous reset, active low
//   bus   - vga_if master: i_en in, raster coordinates and strobes out
// Build option: VGA_PIX_DIV_EN defined -> pixel tick every second enabled
// clock (i_clk/2); undefined -> pixel tick on every enabled clock.
// Counters are registers; every other output is a registered decode of the
// counter/phase state and therefore lags the coordinates by one clock.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int CNT_WIDTH = 10
) (
    input  logic  i_clk,
    input  logic  i_rst,
    vga_if.master bus
);

    logic                 tick;
    logic                 clr;
    logic [CNT_WIDTH-1:0] h_cnt;
    logic [CNT_WIDTH-1:0] v_cnt;
    phase_t               h_phase;
    phase_t               v_phase;
    logic                 h_wrap;
    logic                 v_wrap;
    logic                 vis;
    logic                 at_origin;

    logic hsync_q;
    logic vsync_q;
    logic active_q;
    logic addr_inc_q;
    logic pix_tick_q;
    logic frame_start_q;

    assign clr = !bus.i_en;

`ifdef VGA_PIX_DIV_EN
    logic div;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            div <= 1'b0;
        end else if (clr) begin
            div <= 1'b0;
        end else begin
            div <= ~div;
        end
    end

    assign tick = bus.i_en && div;
`else
    assign tick = bus.i_en;
`endif

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .WIDTH  (CNT_WIDTH)
    ) u_h_axis (
        .clk    (i_clk),
        .rst_n  (i_rst),
        .clr    (clr),
        .step   (tick),
        .cnt    (h_cnt),
        .phase  (h_phase),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .WIDTH  (CNT_WIDTH)
    ) u_v_axis (
        .clk    (i_clk),
        .rst_n  (i_rst),
        .clr    (clr),
        .step   (h_wrap),
        .cnt    (v_cnt),
        .phase  (v_phase),
        .wrap   (v_wrap)
    );

    assign vis = (h_phase == PH_ACT) && (v_phase == PH_ACT);

    // Flags that the current position is (0,0); avoids full-width compares of
    // both counters. Set whenever the raster is held or is about to wrap.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            at_origin <= 1'b1;
        end else if (clr || v_wrap) begin
            at_origin <= 1'b1;
        end else if (tick) begin
            at_origin <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b0;
            addr_inc_q    <= 1'b0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= (h_phase != PH_SYNC);
            vsync_q       <= (v_phase != PH_SYNC);
            active_q      <= vis;
            addr_inc_q    <= tick && vis;
            pix_tick_q    <= tick;
            frame_start_q <= tick && at_origin;
        end
    end

    assign bus.o_h_cnt       = h_cnt;
    assign bus.o_v_cnt       = v_cnt;
    assign bus.o_hsync       = hsync_q;
    assign bus.o_vsync       = vsync_q;
    assign bus.o_active      = active_q;
    assign bus.o_addr_inc    = addr_inc_q;
    assign bus.o_pix_tick    = pix_tick_q;
    assign bus.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Two generators share clock, reset and enable: a reduced-timing instance
// (32x17 raster) for whole-frame scenarios and a default-timing 640x480
// instance for line-level scenarios. Expected values come from position
// arithmetic on the number of pixel ticks elapsed since the raster origin.
module tb_vga_sync_gen;
    import vga_pkg::*;

`ifdef VGA_PIX_DIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    localparam int S_HA = 20, S_HF = 3, S_HS = 4, S_HB = 5;
    localparam int S_VA = 10, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int F_HA = 640, F_HF = 16, F_HS = 96, F_HB = 48;
    localparam int F_VA = 480, F_VF = 10, F_VS = 2, F_VB = 33;

    localparam logic [25:0] RESET_VEC = {10'd0, 10'd0, 6'b110000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    int checks = 0;
    int errors = 0;
    int n = 0;

    vga_if #(.CNT_WIDTH(10)) sbus ();
    vga_if #(.CNT_WIDTH(10)) fbus ();

    assign sbus.i_en = en;
    assign fbus.i_en = en;

    vga_sync_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .CNT_WIDTH (10)
    ) u_small (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (sbus)
    );

    vga_sync_gen u_full (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (fbus)
    );

    always #5 clk = ~clk;

    // {h, v, hsync, vsync, active, addr_inc, pix_tick, frame_start}
    logic [25:0] s_obs;
    logic [25:0] f_obs;
    assign s_obs = {sbus.o_h_cnt, sbus.o_v_cnt, sbus.o_hsync, sbus.o_vsync,
                    sbus.o_active, sbus.o_addr_inc, sbus.o_pix_tick, sbus.o_frame_start};
    assign f_obs = {fbus.o_h_cnt, fbus.o_v_cnt, fbus.o_hsync, fbus.o_vsync,
                    fbus.o_active, fbus.o_addr_inc, fbus.o_pix_tick, fbus.o_frame_start};

    // Expected outputs after the n-th enabled clock edge since the origin.
    // Ticks happen on every DIV-th enabled edge; decodes reflect the position
    // held just before that edge, counters the position just after it.
    function automatic logic [25:0] model(input int cnt_n,
                                          input int ha, input int hf, input int hs, input int hb,
                                          input int va, input int vf, input int vs, input int vb);
        int   ht, vt, c, pre, post, ph, pv;
        logic tk, act, hsn, vsn;
        ht   = ha + hf + hs + hb;
        vt   = va + vf + vs + vb;
        c    = cnt_n - 1;
        pre  = c / DIV;
        post = cnt_n / DIV;
        tk   = ((c % DIV) == DIV - 1);
        ph   = pre % ht;
        pv   = (pre / ht) % vt;
        act  = (ph < ha) && (pv < va);
        hsn  = !((ph >= ha + hf) && (ph < ha + hf + hs));
        vsn  = !((pv >= va + vf) && (pv < va + vf + vs));
        return {10'(post % ht), 10'((post / ht) % vt), hsn, vsn, act,
                tk && act, tk, tk && (ph == 0) && (pv == 0)};
    endfunction

    task automatic step_clk();
        @(posedge clk);
        if (en) n++;
        else    n = 0;
        @(negedge clk);
    endtask

    task automatic restart();
        en = 1'b0;
        step_clk();
        en = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (s_obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_small: got %h expected %h", s_obs, RESET_VEC);
        end
        checks++;
        if (f_obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_full: got %h expected %h", f_obs, RESET_VEC);
        end
        rst_n = 1'b1;
        en    = 1'b1;
        n     = 0;
    endtask

    task automatic test_frame();
        logic [25:0] exp_v;
        int fs1, fs2, inc_cnt, inc_rise, pt_cnt, vs_low;
        logic prev_inc;
        bit   in_win;
        fs1 = -1; fs2 = -1; inc_cnt = 0; inc_rise = 0; pt_cnt = 0; vs_low = 0;
        in_win = 1'b0;
        restart();
        prev_inc = sbus.o_addr_inc;
        for (int i = 0; i < 2 * S_HT * S_VT * DIV + 4; i++) begin
            step_clk();
            exp_v = model(n, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
            checks++;
            if (s_obs !== exp_v) begin
                errors++;
                $display("FAIL frame_outputs n=%0d: got %h expected %h", n, s_obs, exp_v);
            end
            if (sbus.o_frame_start) begin
                if (fs1 < 0) begin
                    fs1 = n;
                    in_win = 1'b1;
                end else if (fs2 < 0) begin
                    fs2 = n;
                    in_win = 1'b0;
                end
            end
            if (in_win) begin
                if (sbus.o_addr_inc) inc_cnt++;
                if (sbus.o_addr_inc && !prev_inc) inc_rise++;
                if (sbus.o_pix_tick) pt_cnt++;
                if (!sbus.o_vsync) vs_low++;
            end
            prev_inc = sbus.o_addr_inc;
        end
        checks++;
        if (fs1 != DIV) begin
            errors++;
            $display("FAIL first_frame_start: got clock %0d expected %0d", fs1, DIV);
        end
        checks++;
        if (fs2 < 0 || fs2 - fs1 != S_HT * S_VT * DIV) begin
            errors++;
            $display("FAIL frame_period: got %0d expected %0d", fs2 - fs1, S_HT * S_VT * DIV);
        end
        checks++;
        if (inc_cnt != S_HA * S_VA) begin
            errors++;
            $display("FAIL addr_inc_count: got %0d expected %0d", inc_cnt, S_HA * S_VA);
        end
        checks++;
        if (inc_rise != ((DIV == 1) ? S_VA : S_HA * S_VA)) begin
            errors++;
            $display("FAIL addr_inc_pulses: got %0d expected %0d", inc_rise,
                     (DIV == 1) ? S_VA : S_HA * S_VA);
        end
        checks++;
        if (pt_cnt != S_HT * S_VT) begin
            errors++;
            $display("FAIL pix_tick_count: got %0d expected %0d", pt_cnt, S_HT * S_VT);
        end
        checks++;
        if (vs_low != S_VS * S_HT * DIV) begin
            errors++;
            $display("FAIL vsync_low_clocks: got %0d expected %0d", vs_low, S_VS * S_HT * DIV);
        end
    endtask

    task automatic test_line_full();
        logic [25:0] exp_v;
        int   prev_h, prev_v, hs_low, fall_h, bad_act;
        logic prev_hs;
        hs_low = 0; fall_h = -1; bad_act = 0;
        restart();
        prev_h  = int'(fbus.o_h_cnt);
        prev_v  = int'(fbus.o_v_cnt);
        prev_hs = fbus.o_hsync;
        for (int i = 0; i < 2 * F_HA * 0 + 2 * 800 * DIV + 4; i++) begin
            step_clk();
            exp_v = model(n, F_HA, F_HF, F_HS, F_HB, F_VA, F_VF, F_VS, F_VB);
            checks++;
            if (f_obs !== exp_v) begin
                errors++;
                $display("FAIL line_outputs n=%0d: got %h expected %h", n, f_obs, exp_v);
            end
            if (n >= 1 && n <= 800 * DIV && !fbus.o_hsync) hs_low++;
            if (prev_hs && !fbus.o_hsync && fall_h < 0) fall_h = prev_h;
            if (fbus.o_active && (prev_h >= F_HA || prev_v >= F_VA)) bad_act++;
            prev_h  = int'(fbus.o_h_cnt);
            prev_v  = int'(fbus.o_v_cnt);
            prev_hs = fbus.o_hsync;
        end
        checks++;
        if (hs_low != F_HS * DIV) begin
            errors++;
            $display("FAIL hsync_width: got %0d expected %0d", hs_low, F_HS * DIV);
        end
        checks++;
        if (fall_h != F_HA + F_HF) begin
            errors++;
            $display("FAIL hsync_start: got h=%0d expected h=%0d", fall_h, F_HA + F_HF);
        end
        checks++;
        if (bad_act != 0) begin
            errors++;
            $display("FAIL active_outside: got %0d clocks expected 0", bad_act);
        end
    endtask

    task automatic test_enable_drop();
        logic [25:0] exp_v;
        int run_len, low_len, k;
        run_len = $urandom_range(40, 600);
        low_len = $urandom_range(5, 15);
        restart();
        for (int i = 0; i < run_len; i++) begin
            step_clk();
            exp_v = model(n, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
            checks++;
            if (s_obs !== exp_v) begin
                errors++;
                $display("FAIL pre_drop n=%0d: got %h expected %h", n, s_obs, exp_v);
            end
        end
        en = 1'b0;
        for (int i = 0; i < low_len; i++) begin
            step_clk();
            checks++;
            if ({sbus.o_h_cnt, sbus.o_v_cnt, sbus.o_addr_inc, sbus.o_pix_tick,
                 sbus.o_frame_start} !== 23'd0) begin
                errors++;
                $display("FAIL en_low_hold: got h=%0d v=%0d inc=%b tick=%b fs=%b expected all 0",
                         sbus.o_h_cnt, sbus.o_v_cnt, sbus.o_addr_inc, sbus.o_pix_tick,
                         sbus.o_frame_start);
            end
        end
        en = 1'b1;
        k = 0;
        while (k < 10 && !sbus.o_frame_start) begin
            step_clk();
            k++;
        end
        checks++;
        if (!sbus.o_frame_start || n != DIV) begin
            errors++;
            $display("FAIL reenable_frame_start: got fs=%b at clock %0d expected 1 at %0d",
                     sbus.o_frame_start, n, DIV);
        end
        checks++;
        if (sbus.o_h_cnt !== 10'd1 || sbus.o_v_cnt !== 10'd0) begin
            errors++;
            $display("FAIL reenable_pos: got (%0d,%0d) expected (1,0)", sbus.o_h_cnt, sbus.o_v_cnt);
        end
    endtask

    task automatic test_reset_mid_sync();
        logic [25:0] exp_v;
        int k;
        restart();
        k = 0;
        while (k < 2000 * DIV && fbus.o_h_cnt !== 10'd700) begin
            step_clk();
            k++;
        end
        checks++;
        if (fbus.o_h_cnt !== 10'd700 || fbus.o_hsync !== 1'b0) begin
            errors++;
            $display("FAIL reach_sync: got h=%0d hsync=%b expected h=700 hsync=0",
                     fbus.o_h_cnt, fbus.o_hsync);
        end
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        checks++;
        if (f_obs !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset_full: got %h expected %h", f_obs, RESET_VEC);
        end
        checks++;
        if (s_obs !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset_small: got %h expected %h", s_obs, RESET_VEC);
        end
        step_clk();
        step_clk();
        checks++;
        if (f_obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_hold_full: got %h expected %h", f_obs, RESET_VEC);
        end
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            step_clk();
            exp_v = model(n, F_HA, F_HF, F_HS, F_HB, F_VA, F_VF, F_VS, F_VB);
            checks++;
            if (f_obs !== exp_v) begin
                errors++;
                $display("FAIL post_reset n=%0d: got %h expected %h", n, f_obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_line_full();
        test_enable_drop();
        test_reset_mid_sync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
